// File: rtl/mips_sopc_pkg.sv
// Shared definitions for the mips_sopc core: ISA encodings, ALU operations,
// pipeline bundles and the ID-stage operand forwarding helper.
package mips_defs;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_PREF    = 6'h33;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_SYNC = 6'h0F;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_LUI,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef struct packed {
    logic            write_en;
    logic [4:0]      write_addr;
    logic [XLEN-1:0] write_data;
  } wb_bundle_t;

  // Shift instructions carry the shift amount in src1[4:0].
  typedef struct packed {
    alu_op_e         alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            write_en;
    logic [4:0]      write_addr;
  } id_ex_t;

  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [4:0]      addr,
    input wb_bundle_t      ex,
    input wb_bundle_t      mem,
    input wb_bundle_t      wb,
    input logic [XLEN-1:0] rf_data
  );
    if (addr == 5'd0)                              return '0;
    if (ex.write_en  && (ex.write_addr  == addr))  return ex.write_data;
    if (mem.write_en && (mem.write_addr == addr))  return mem.write_data;
    if (wb.write_en  && (wb.write_addr  == addr))  return wb.write_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/mips_cpu.sv
// Five-stage MIPS32 integer core (logic/shift/no-op subset). MEM is a pure
// pass-through since there is no data memory; ID forwards from EX, MEM, WB.
module mips_cpu
  import mips_defs::*;
#(
  parameter int AW = 10
) (
  input  logic            i_clk,
  input  logic            i_srst,
  input  logic [XLEN-1:0] i_instr,
  output logic [AW-1:0]   o_pc_word
);

  logic [AW-1:0]   r_pc;
  logic [XLEN-1:0] r_if_id_instr;
  id_ex_t          r_id_ex;
  id_ex_t          w_id_ex;
  wb_bundle_t      w_ex;
  wb_bundle_t      r_ex_mem;
  wb_bundle_t      r_mem_wb;
  logic            w_dec_valid;

  logic [5:0]      w_opcode;
  logic [5:0]      w_funct;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_sa;
  logic [15:0]     w_imm;
  logic [4:0]      w_rf_addr [2];
  logic [XLEN-1:0] w_rf_data [2];
  logic [XLEN-1:0] w_opnd    [2];

  assign o_pc_word = r_pc;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_pc          <= '0;
      r_if_id_instr <= '0;
    end else begin
      r_pc          <= r_pc + AW'(1);
      r_if_id_instr <= i_instr;
    end
  end

  assign w_opcode     = r_if_id_instr[31:26];
  assign w_rf_addr[0] = r_if_id_instr[25:21];
  assign w_rf_addr[1] = r_if_id_instr[20:16];
  assign w_rt         = r_if_id_instr[20:16];
  assign w_rd         = r_if_id_instr[15:11];
  assign w_sa         = r_if_id_instr[10:6];
  assign w_funct      = r_if_id_instr[5:0];
  assign w_imm        = r_if_id_instr[15:0];

  mips_regfile register (
    .i_clk   (i_clk),
    .i_wr    (r_mem_wb),
    .i_raddr (w_rf_addr),
    .o_rdata (w_rf_data)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    assign w_opnd[gi] = fwd_operand(w_rf_addr[gi], w_ex, r_ex_mem, r_mem_wb, w_rf_data[gi]);
  end

  always_comb begin
    w_dec_valid    = 1'b0;
    w_id_ex        = '0;
    w_id_ex.alu_op = ALU_NONE;
    case (w_opcode)
      OP_SPECIAL: begin
        w_dec_valid        = 1'b1;
        w_id_ex.write_addr = w_rd;
        w_id_ex.src1       = w_opnd[0];
        w_id_ex.src2       = w_opnd[1];
        case (w_funct)
          FN_SLL:  begin w_id_ex.alu_op = ALU_SLL; w_id_ex.src1 = XLEN'(w_sa); end
          FN_SRL:  begin w_id_ex.alu_op = ALU_SRL; w_id_ex.src1 = XLEN'(w_sa); end
          FN_SRA:  begin w_id_ex.alu_op = ALU_SRA; w_id_ex.src1 = XLEN'(w_sa); end
          FN_SLLV: w_id_ex.alu_op = ALU_SLL;
          FN_SRLV: w_id_ex.alu_op = ALU_SRL;
          FN_SRAV: w_id_ex.alu_op = ALU_SRA;
          FN_AND:  w_id_ex.alu_op = ALU_AND;
          FN_OR:   w_id_ex.alu_op = ALU_OR;
          FN_XOR:  w_id_ex.alu_op = ALU_XOR;
          FN_NOR:  w_id_ex.alu_op = ALU_NOR;
          default: w_dec_valid    = 1'b0;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_dec_valid        = 1'b1;
        w_id_ex.write_addr = w_rt;
        w_id_ex.src1       = w_opnd[0];
        w_id_ex.src2       = XLEN'(w_imm);
        case (w_opcode)
          OP_ANDI: w_id_ex.alu_op = ALU_AND;
          OP_ORI:  w_id_ex.alu_op = ALU_OR;
          default: w_id_ex.alu_op = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        w_dec_valid        = 1'b1;
        w_id_ex.write_addr = w_rt;
        w_id_ex.src2       = {w_imm, 16'h0000};
        w_id_ex.alu_op     = ALU_LUI;
      end
      default: w_dec_valid = 1'b0;
    endcase
    // Dropping writes to $0 here keeps it out of the forwarding paths too.
    w_id_ex.write_en = w_dec_valid && (w_id_ex.write_addr != 5'd0);
  end

  always_comb begin
    w_ex.write_en   = r_id_ex.write_en;
    w_ex.write_addr = r_id_ex.write_addr;
    case (r_id_ex.alu_op)
      ALU_AND: w_ex.write_data = r_id_ex.src1 & r_id_ex.src2;
      ALU_OR:  w_ex.write_data = r_id_ex.src1 | r_id_ex.src2;
      ALU_XOR: w_ex.write_data = r_id_ex.src1 ^ r_id_ex.src2;
      ALU_NOR: w_ex.write_data = ~(r_id_ex.src1 | r_id_ex.src2);
      ALU_LUI: w_ex.write_data = r_id_ex.src2;
      ALU_SLL: w_ex.write_data = r_id_ex.src2 << r_id_ex.src1[4:0];
      ALU_SRL: w_ex.write_data = r_id_ex.src2 >> r_id_ex.src1[4:0];
      ALU_SRA: w_ex.write_data = XLEN'($signed(r_id_ex.src2) >>> r_id_ex.src1[4:0]);
      default: w_ex.write_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_id_ex  <= '0;
      r_ex_mem <= '0;
      r_mem_wb <= '0;
    end else begin
      r_id_ex  <= w_id_ex;
      r_ex_mem <= w_ex;
      r_mem_wb <= r_ex_mem;
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// 32 x XLEN register file, two combinational read ports with write-through
// bypass, one synchronous write port; register 0 is hardwired to zero.
module mips_regfile
  import mips_defs::*;
(
  input  logic            i_clk,
  input  wb_bundle_t      i_wr,
  input  logic [4:0]      i_raddr [2],
  output logic [XLEN-1:0] o_rdata [2]
);

  logic [XLEN-1:0] storage [0:31];

  always_ff @(posedge i_clk) begin
    storage[0] <= '0;
    if (i_wr.write_en && (i_wr.write_addr != 5'd0)) begin
      storage[i_wr.write_addr] <= i_wr.write_data;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign o_rdata[gi] = (i_raddr[gi] == 5'd0) ? '0 :
                         (i_wr.write_en && (i_wr.write_addr == i_raddr[gi])) ? i_wr.write_data :
                         storage[i_raddr[gi]];
  end

endmodule

// File: rtl/mips_rom.sv
// Instruction ROM with combinational word read; contents are loaded from
// outside the design through the storage array.
module mips_rom #(
  parameter  int WORDS  = 1024,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(WORDS)
) (
  input  logic [AW-1:0]     i_addr,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] storage [0:WORDS-1];

  assign o_data = storage[i_addr];

endmodule

// File: rtl/mips_sopc.sv
// Simulation SoC wrapper: MIPS core `cpu` fetching from instruction ROM `rom`.
module mips_sopc #(
  parameter int ROM_WORDS = 1024,
  parameter int XLEN      = 32
) (
  input logic clock,
  input logic reset
);

  localparam int AW = $clog2(ROM_WORDS);

  logic [AW-1:0]   w_pc_word;
  logic [XLEN-1:0] w_instr;

  mips_cpu #(
    .AW (AW)
  ) cpu (
    .i_clk     (clock),
    .i_srst    (reset),
    .i_instr   (w_instr),
    .o_pc_word (w_pc_word)
  );

  mips_rom #(
    .WORDS  (ROM_WORDS),
    .DATA_W (XLEN)
  ) rom (
    .i_addr (w_pc_word),
    .o_data (w_instr)
  );

endmodule

// File: tb/tb_mips_sopc.sv
// Scoreboard bench for mips_sopc: each fetched word queues its expected
// register result, which is checked on the edge it is due to retire.
module tb_mips_sopc;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mips_sopc #(
    .ROM_WORDS (1024),
    .XLEN      (32)
  ) dut (
    .clock (clock),
    .reset (reset)
  );

  localparam int NPROG = 27;

  typedef struct {
    int          due;
    int          word;
    int          reg_idx;
    logic [31:0] val;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] snap2;

  logic [31:0] prog [NPROG] = '{
    32'h3C020404, 32'h34420404, 32'h34070007, 32'h34050005, 32'h34080008,
    32'h0000100F, 32'h00021200, 32'h00E21004, 32'h00021202, 32'h00A21006,
    32'h00000000, 32'hCC020000, 32'h000214C0, 32'h00000040, 32'h00021403,
    32'h01021007, 32'h3400FFFF, 32'h384900FF, 32'h01225024, 32'h01475825,
    32'h01656026, 32'h01806827, 32'h31AE00F0, 32'hFC02FFFF, 32'h000D7903,
    32'h0000103F, 32'h018D8006
  };

  int exp_reg [NPROG] = '{
    2, 2, 7, 5, 8,
    2, 2, 2, 2, 2,
    2, 2, 2, 2, 2,
    2, 0, 9, 10, 11,
    12, 13, 14, 2, 15,
    2, 16
  };

  logic [31:0] exp_val [NPROG] = '{
    32'h04040000, 32'h04040404, 32'h00000007, 32'h00000005, 32'h00000008,
    32'h04040404, 32'h04040400, 32'h02020000, 32'h00020200, 32'h00001010,
    32'h00001010, 32'h00001010, 32'h80800000, 32'h80800000, 32'hFFFF8080,
    32'hFFFFFF80, 32'h00000000, 32'hFFFFFF7F, 32'hFFFFFF00, 32'hFFFFFF07,
    32'hFFFFFF02, 32'h000000FD, 32'h000000F0, 32'hFFFFFF80, 32'h0000000F,
    32'hFFFFFF80, 32'h0000003F
  };

  function automatic logic [31:0] rf(input int r);
    return dut.cpu.register.storage[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs the program from reset release, holding $2 against a snapshot for
  // the first four edges while the pipeline fills.
  task automatic run_program(input int n_edges);
    sb_entry_t ent;
    sb_q.delete();
    for (int e = 1; e <= n_edges; e++) begin
      step();
      if (e - 1 < NPROG) begin
        sb_q.push_back('{due: e + 4, word: e - 1, reg_idx: exp_reg[e - 1], val: exp_val[e - 1]});
      end
      if (e <= 4) begin
        chk($sformatf("fill_e%0d_r2", e), rf(2), snap2);
      end
      while ((sb_q.size() > 0) && (sb_q[0].due == e)) begin
        ent = sb_q.pop_front();
        chk($sformatf("w%0d_r%0d_e%0d", ent.word, ent.reg_idx, e), rf(ent.reg_idx), ent.val);
      end
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dut.rom.storage[i] = 32'h0;
    end
    for (int i = 0; i < NPROG; i++) begin
      dut.rom.storage[i] = prog[i];
    end

    reset = 1'b1;
    repeat (3) step();
    chk("reset_r0", rf(0), 32'h0);
    snap2 = rf(2);
    reset = 1'b0;
    run_program(NPROG + 6);

    chk("final_r0", rf(0), 32'h0);
    chk("final_r5", rf(5), 32'h00000005);
    chk("final_r7", rf(7), 32'h00000007);
    chk("final_r8", rf(8), 32'h00000008);
    chk("final_r2", rf(2), 32'hFFFFFF80);

    // Reset again mid-program with instructions still in flight.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    repeat (2) step();
    snap2 = rf(2);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e <= 4) begin
        chk($sformatf("rst2_e%0d_r2", e), rf(2), snap2);
        chk($sformatf("rst2_e%0d_r0", e), rf(0), 32'h0);
      end else if (e == 5) begin
        chk("rst2_e5_r2", rf(2), 32'h04040000);
      end else begin
        chk("rst2_e6_r2", rf(2), 32'h04040404);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
